apb_req_arbiter: RTL

Round-robin arbiter that shares one apb_master instance among NUM_REQ local requesters. It sits between the requesters, such as DMA, CPU bridge or config sequencers, and the apb_master native request port. It grants one requester at a time and registers that requester's address, direction and write data. It drives the master until the transfer completes, then routes the completion and read data back to the granted requester.

---
 rtl/apb_req_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master request port among NUM_REQ requesters.
// The winner's request is registered and held on the master port until completion.
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          i_clk_apb,
  input  logic                          i_rst_apb,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0]            i_req_rd0_wr1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wr_data,
  output logic [NUM_REQ-1:0]            o_req_rd_valid,
  output logic [DATA_WIDTH-1:0]         o_req_rd_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_m_valid,
  input  logic                          i_m_ready,
  output logic [ADDR_WIDTH-1:0]         o_m_addr,
  output logic                          o_m_rd0_wr1,
  output logic [DATA_WIDTH-1:0]         o_m_wr_data,
  input  logic                          i_m_rd_valid,
  input  logic [DATA_WIDTH-1:0]         i_m_rd_data
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StRdWait} state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic                  m_valid_q, m_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  found;
  logic [PtrW-1:0]       win;
  int unsigned           idx;
  logic                  rd_ret;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!found && i_req_valid[idx[PtrW-1:0]]) begin
        found = 1'b1;
        win   = idx[PtrW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    m_valid_d = m_valid_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d   = NUM_REQ'(1) << win;
          addr_d    = i_req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
          wr_d      = i_req_rd0_wr1[win];
          wdata_d   = i_req_wr_data[win*DATA_WIDTH +: DATA_WIDTH];
          m_valid_d = 1'b1;
          state_d   = StBusy;
          ptr_d     = (win == PtrW'(NUM_REQ - 1)) ? '0 : win + PtrW'(1);
        end
      end
      StBusy: begin
        if (i_m_ready) begin
          m_valid_d = 1'b0;
          // Read data arriving with the handshake finishes the read in one step.
          if (wr_q || i_m_rd_valid) begin
            state_d = StIdle;
            grant_d = '0;
          end else begin
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        if (i_m_rd_valid) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_apb) begin
    if (i_rst_apb) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rd_ret = i_m_rd_valid && !wr_q && (state_q == StBusy || state_q == StRdWait);

  assign o_req_ready    = (state_q == StBusy && i_m_ready) ? grant_q : '0;
  assign o_req_rd_valid = rd_ret ? grant_q : '0;
  assign o_req_rd_data  = rd_ret ? i_m_rd_data : '0;
  assign o_grant        = grant_q;
  assign o_m_valid      = m_valid_q;
  assign o_m_addr       = addr_q;
  assign o_m_rd0_wr1    = wr_q;
  assign o_m_wr_data    = wdata_q;

endmodule
